// File: rtl/alu_mc_pkg.sv
// Shared opcode encodings, FSM state type and flag bit positions for alu_mc.
package alu_mc_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_NOTA = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_NAND = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_XNOR = 4'd10;
    localparam logic [3:0] OP_MOD  = 4'd11;
    localparam logic [3:0] OP_INC  = 4'd12;
    localparam logic [3:0] OP_DEC  = 4'd13;
    localparam logic [3:0] OP_LNOT = 4'd14;
    localparam logic [3:0] OP_MULH = 4'd15;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int F_Z  = 0;
    localparam int F_C  = 1;
    localparam int F_V  = 2;
    localparam int F_DZ = 3;

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative shift-add multiplier / restoring divider on one 2*WIDTH accumulator.
// done strobes during the last iteration; res carries that iteration's outcome.
module alu_mc_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] res
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0]   opnd;
    logic [CW-1:0]      cnt;
    logic               busy, div_q;
    logic [WIDTH:0]     sum, sh, trial;

    // mul: {hi,lo} = {partial, multiplier}; div: {hi,lo} = {remainder, dividend/quotient}
    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        sh    = acc[2*WIDTH-1:WIDTH-1];
        trial = sh - {1'b0, opnd};
        if (!div_q)
            acc_nxt = {sum, acc[WIDTH-1:1]};
        else if (!trial[WIDTH])
            acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_nxt = {sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    assign done = busy && (cnt == CW'(1));
    assign res  = acc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            opnd  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            div_q <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CW'(WIDTH);
            div_q <= div;
            opnd  <= div ? b : a;
            acc   <= {{WIDTH{1'b0}}, div ? a : b};
        end else if (busy) begin
            acc <= acc_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes and {dz,v,c,z} flags.
// Define ALU_MC_FAST_MUL_EN to run opcodes 2/15 on a single-cycle multiplier.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    localparam int MSB = WIDTH - 1;

    state_t             state;
    logic [3:0]         op_q;
    logic               bz_q, accept, iter_op, is_div, it_done;
    logic [2*WIDTH-1:0] it_res;
    logic [WIDTH-1:0]   opb, sc_res, it_word;
    logic [WIDTH:0]     sum, dif;
    logic               sc_c, sc_v, it_dz;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign is_div    = (sel == OP_DIV) || (sel == OP_MOD);

`ifdef ALU_MC_FAST_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod    = a * b;
    assign iter_op = is_div;
`else
    assign iter_op = is_div || (sel == OP_MUL) || (sel == OP_MULH);
`endif

    // increment/decrement reuse the add/sub path with an implicit operand of 1
    always_comb begin
        opb    = (sel == OP_ADD || sel == OP_SUB) ? b : WIDTH'(1);
        sum    = {1'b0, a} + {1'b0, opb};
        dif    = {1'b0, a} - {1'b0, opb};
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (sel)
            OP_ADD, OP_INC: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (a[MSB] == opb[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB, OP_DEC: begin
                sc_res = dif[WIDTH-1:0];
                sc_c   = dif[WIDTH];
                sc_v   = (a[MSB] != opb[MSB]) && (dif[MSB] != a[MSB]);
            end
            OP_NOTA: sc_res = ~a;
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_NAND: sc_res = ~(a & b);
            OP_NOR:  sc_res = ~(a | b);
            OP_XOR:  sc_res = a ^ b;
            OP_XNOR: sc_res = ~(a ^ b);
            OP_LNOT: sc_res = {{(WIDTH-1){1'b0}}, (a == '0)};
`ifdef ALU_MC_FAST_MUL_EN
            OP_MUL:  sc_res = prod[WIDTH-1:0];
            OP_MULH: sc_res = prod[2*WIDTH-1:WIDTH];
`endif
            default: sc_res = '0;
        endcase
    end

    alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (accept && iter_op),
        .div   (is_div),
        .a     (a),
        .b     (b),
        .done  (it_done),
        .res   (it_res)
    );

    // low half is product-low / quotient, high half is product-high / remainder
    always_comb begin
        it_word = (op_q == OP_MUL || op_q == OP_DIV) ? it_res[WIDTH-1:0]
                                                     : it_res[2*WIDTH-1:WIDTH];
        it_dz   = bz_q && (op_q == OP_DIV || op_q == OP_MOD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= '0;
            bz_q   <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q <= sel;
                    bz_q <= (b == '0);
                    if (iter_op) begin
                        state <= CALC;
                    end else begin
                        state  <= DONE;
                        result <= sc_res;
                        flags  <= {1'b0, sc_v, sc_c, (sc_res == '0)};
                    end
                end
                CALC: if (it_done) begin
                    state  <= DONE;
                    result <= it_word;
                    flags  <= {it_dz, 1'b0, 1'b0, (it_word == '0)};
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (WIDTH=8) with hand-computed expectations.
module tb_alu_mc;
    localparam int W = 8;
`ifdef ALU_MC_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 9;
`endif
    localparam int DIV_LAT = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [W-1:0] a = '0, b = '0, result;
    logic [3:0]   sel = '0, flags;
    int           total = 0, bad = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure accept-to-out_valid latency, check result/flags.
    // Leaves the block in DONE with out_ready low.
    task automatic issue(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [3:0] ts, input int lat,
                         input logic [W-1:0] er, input logic [3:0] ef);
        int n;
        @(negedge clk);
        chk({tag, ".in_ready"}, in_ready, 1);
        a = ta; b = tb; sel = ts; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; a = ~ta; b = ~tb; sel = ~ts;
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".lat"}, n, lat);
        chk({tag, ".res"}, result, er);
        chk({tag, ".flags"}, flags, ef);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".drain_ov"}, out_valid, 0);
    endtask

    initial begin
        logic seen;
        #2;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.result", result, 0);
        chk("rst.flags", flags, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.in_ready", in_ready, 1);

        // flags order {dz, v, c, z}
        issue("add", 8'd200, 8'd100, 4'd0, 1, 8'h2C, 4'b0010);   drain("add");
        issue("inc", 8'd127, 8'd0, 4'd12, 1, 8'h80, 4'b0100);    drain("inc");
        issue("sub", 8'd5, 8'd7, 4'd1, 1, 8'hFE, 4'b0010);       drain("sub");
        issue("lnot", 8'd0, 8'd0, 4'd14, 1, 8'h01, 4'b0000);     drain("lnot");
        issue("xor", 8'h0F, 8'h0F, 4'd9, 1, 8'h00, 4'b0001);     drain("xor");
        issue("dec0", 8'h00, 8'd0, 4'd13, 1, 8'hFF, 4'b0010);    drain("dec0");
        issue("dec80", 8'h80, 8'd0, 4'd13, 1, 8'h7F, 4'b0100);   drain("dec80");
        issue("nota", 8'hFF, 8'd0, 4'd4, 1, 8'h00, 4'b0001);     drain("nota");
        issue("nand", 8'hF0, 8'h3C, 4'd7, 1, 8'hCF, 4'b0000);    drain("nand");
        issue("mul", 8'd200, 8'd3, 4'd2, MUL_LAT, 8'h58, 4'b0000);  drain("mul");
        issue("mulh", 8'd200, 8'd3, 4'd15, MUL_LAT, 8'h02, 4'b0000); drain("mulh");
        issue("div", 8'd200, 8'd7, 4'd3, DIV_LAT, 8'd28, 4'b0000);   drain("div");
        issue("mod", 8'd200, 8'd7, 4'd11, DIV_LAT, 8'd4, 4'b0000);   drain("mod");
        issue("div0", 8'd200, 8'd0, 4'd3, DIV_LAT, 8'hFF, 4'b1000);  drain("div0");
        issue("mod0", 8'd200, 8'd0, 4'd11, DIV_LAT, 8'd200, 4'b1000); drain("mod0");

        // backpressure: result held, new requests ignored
        issue("bp", 8'd10, 8'd20, 4'd0, 1, 8'd30, 4'b0000);
        a = 8'd1; b = 8'd1; sel = 4'd0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.ov", out_valid, 1);
            chk("bp.res", result, 30);
            chk("bp.flags", flags, 0);
            chk("bp.in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp.release_ov", out_valid, 0);
        chk("bp.release_ir", in_ready, 1);
        chk("bp.release_res", result, 30);

        // reset aborts an in-flight divide
        @(negedge clk);
        a = 8'd200; b = 8'd7; sel = 4'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort.busy", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("abort.ov", out_valid, 0);
        chk("abort.res", result, 0);
        chk("abort.flags", flags, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort.in_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort.no_ov", seen, 0);
        issue("post", 8'd1, 8'd2, 4'd0, 1, 8'd3, 4'b0000); drain("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle arithmetic logic unit with valid/ready handshakes on both sides and a status-flag output. It keeps the 16-entry opcode space of the team's combinational 4-bit ALU, generalised to WIDTH bits. Multiply, divide and modulo run iteratively over WIDTH cycles; all other operations complete in one cycle. It sits between an operand/issue stage and a result consumer that may apply backpressure.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands and opcode presented
- in_ready  out  1  block can accept; high only in IDLE
- a  in  WIDTH  operand A (unsigned; signed view used only for v)
- b  in  WIDTH  operand B
- sel  in  4  opcode
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- flags  out  4  {dz, v, c, z}, registered with result

## Operation
- Opcodes: 0 a+b, 1 a−b, 2 low WIDTH bits of a·b, 3 a/b, 4 ~a, 5 a&b, 6 a|b, 7 ~(a&b), 8 ~(a|b), 9 a^b, 10 ~(a^b), 11 a%b, 12 a+1, 13 a−1, 14 logical not (1 if a==0, else 0), 15 high WIDTH bits of a·b.
- Accept: in_valid && in_ready. a, b and sel are captured; later input changes have no effect.
- FSM states: IDLE, CALC, DONE.
  - IDLE → DONE on accept of any opcode except 2, 3, 11 and 15.
  - IDLE → CALC on accept of opcode 2, 3, 11 or 15.
  - CALC → DONE after exactly WIDTH iteration cycles.
  - DONE → IDLE when out_ready is high.
- Multiply: shift-add, 2·WIDTH-bit product.
- Divide and modulo: restoring division, one quotient bit per cycle.
- b==0 on opcode 3 or 11: still takes WIDTH cycles. Quotient = all ones, remainder = a, dz=1.
- Flags:
  - z: result==0, for every opcode.
  - c: carry out for 0 and 12; borrow for 1 and 13; 0 otherwise.
  - v: two's-complement overflow for 0, 1, 12 and 13; 0 otherwise.
  - dz: set only as described for division by zero.
- All arithmetic is modulo 2^WIDTH.

## Timing
- Reset values: state IDLE, result 0, flags 0, out_valid 0. in_ready reads 1 once rst deasserts.
- in_ready = (state==IDLE). Decoded from the state register; no combinational path from out_ready.
- Single-cycle opcodes: out_valid rises on the edge after accept (latency 1).
- Iterative opcodes: out_valid rises WIDTH+1 edges after accept.
- result and flags update only on entry to DONE. They stay stable while out_valid && !out_ready.
- out_valid falls on the edge where out_valid && out_ready. The next accept is possible one cycle later, so peak throughput is one operation per 2 cycles.
- Reset asserted mid-CALC or in DONE: the operation is aborted, outputs return to reset values immediately, and no out_valid is produced for the aborted operation.
- in_valid held high while busy: ignored, not queued.

## Configuration
- ALU_MC_FAST_MUL_EN defined: opcodes 2 and 15 use a single-cycle combinational multiplier and follow the 1-cycle path (IDLE→DONE). Divide and modulo stay iterative.
- Not defined: multiply uses the shared iterative datapath, WIDTH+1 cycle latency.
- Results and flags are identical in both builds.

## Structure
- Package alu_mc_pkg: opcode localparams (OP_ADD … OP_MULH), state typedef (IDLE/CALC/DONE), flag bit indices.
- Sub-module alu_mc_iter: shift-add multiplier and restoring divider sharing one 2·WIDTH accumulator and a cycle counter. It has start and done strobes and is instantiated once.
- Top level holds the FSM, the single-cycle operation decode, flag generation and output registers.

## Test plan
- WIDTH=8, a=200, b=100, sel=0 → result 0x2C, c=1, v=0, z=0, out_valid 1 cycle after accept. Then a=127, sel=12 → 0x80, v=1, c=0.
- a=5, b=7, sel=1 → result 0xFE, c=1 (borrow), v=0. Then a=0, sel=14 → result 1. Then a=0x0F, b=0x0F, sel=9 → result 0, z=1.
- a=200, b=3: sel=2 → 0x58 and sel=15 → 0x02, out_valid 9 cycles after accept (1 cycle with ALU_MC_FAST_MUL_EN). a=200, b=7: sel=3 → 28, sel=11 → 4.
- a=200, b=0, sel=3 → result 0xFF, dz=1. Same operands with sel=11 → 200, dz=1. Both take 9 cycles.
- Backpressure: hold out_ready low for 5 cycles after out_valid → result and flags stable, in_ready 0, in_valid ignored. Then raise out_ready → IDLE next cycle.
- Assert rst 4 cycles into a divide → out_valid stays 0, result and flags become 0, in_ready is 1 after release, and the next add completes normally.
